// File: rtl/noc_packet_sink_pkg.sv
// Shared definitions for the NoC packet sink. These cover the flit field
// layout, the marker values, the error codes, the FSM state type and a
// saturating counter helper.
//
// Flit layout (32 bits):
//   [31:30] H marker
//   [29:22] source ID {x[3:0], y[3:0]}
//   [21:14] destination ID {x[3:0], y[3:0]}
//   [13:12] E marker
//   [11:0]  unused by the sink
package noc_packet_sink_pkg;

  localparam int NOC_DATA_WIDTH   = 32;
  localparam int NOC_ID_X_WIDTH   = 4;
  localparam int NOC_ID_Y_WIDTH   = 4;
  localparam int NOC_ID_WIDTH     = NOC_ID_X_WIDTH + NOC_ID_Y_WIDTH;
  localparam int NOC_POINT_H      = 30;
  localparam int NOC_SOURCE_POINT = 22;
  localparam int NOC_DEST_POINT   = NOC_SOURCE_POINT - NOC_ID_WIDTH;
  localparam int AXI_LEN_POINT    = 14;
  localparam int NOC_POINT_E      = 12;
  localparam int NOC_MARK_W       = 2;

  localparam logic [NOC_MARK_W-1:0] NOC_HEAD_H = 2'b10;
  localparam logic [NOC_MARK_W-1:0] NOC_HEAD_E = 2'b01;
  localparam logic [NOC_MARK_W-1:0] NOC_TAIL_H = 2'b01;
  localparam logic [NOC_MARK_W-1:0] NOC_TAIL_E = 2'b10;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_NOHDR = 3'd1,
    ERR_DEST  = 3'd2,
    ERR_HMARK = 3'd3,
    ERR_DATA  = 3'd4,
    ERR_OVF   = 3'd5,
    ERR_TAIL  = 3'd6,
    ERR_TRUNC = 3'd7
  } err_code_e;

  typedef enum logic {ST_IDLE, ST_PAYLOAD} state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A packet keeps the first error it sees. Later errors are dropped.
  function automatic err_code_e first_err(input err_code_e cur, input err_code_e nw);
    return (cur != ERR_NONE) ? cur : nw;
  endfunction

endpackage

// File: rtl/noc_lfsr8.sv
// 8-bit Fibonacci LFSR using polynomial x^8+x^6+x^5+x^4+1. It steps on each
// clock edge while en_i is high, and loads SEED on reset.
//   clk_i   clock
//   rst_ni  async reset, active low
//   en_i    step enable
//   state_o current LFSR state
module noc_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q;
  logic       fb;

  assign fb = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   state_q <= SEED;
    else if (en_i) state_q <= {state_q[6:0], fb};
  end

  assign state_o = state_q;

endmodule

// File: rtl/noc_packet_sink.sv
// NoC local-port packet sink and checker. It accepts header/data/tail flits
// under valid/ready, with optional pseudo-random backpressure. It checks
// markers, destination, payload, length and source consistency. It emits one
// status record per packet, plus saturating packet and error counters.
//   noc_clk / noc_rst_n     clock, async active-low reset
//   receive_*               flit input channel (receive_ready is registered)
//   bp_enable               1: LFSR-driven ready, 0: ready held high
//   pkt_done                1-cycle pulse; pkt_src_x/y, pkt_len, pkt_err and
//                           err_code are valid then and hold until the next close
//   pkt_count / err_count   completed packets / errored packets + stray flits
module noc_packet_sink
  import noc_packet_sink_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID           = '0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID           = '0,
  parameter int                        MAX_DATA_FLITS = 16,
  parameter logic [NOC_DATA_WIDTH-1:0] EXP_DATA       = '1,
  parameter bit                        CHECK_DATA     = 1'b1,
  parameter logic [7:0]                BP_SEED        = 8'hA5
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  input  logic                      bp_enable,
  output logic                      pkt_done,
  output logic [NOC_ID_X_WIDTH-1:0] pkt_src_x,
  output logic [NOC_ID_Y_WIDTH-1:0] pkt_src_y,
  output logic [7:0]                pkt_len,
  output logic                      pkt_err,
  output logic [2:0]                err_code,
  output logic [15:0]               pkt_count,
  output logic [15:0]               err_count
);

  localparam logic [NOC_ID_WIDTH-1:0] OWN_ID = {X_ID, Y_ID};

  // Backpressure source
  logic [7:0] lfsr_state;
  logic [6:0] lfsr_unused;

  noc_lfsr8 #(.SEED(BP_SEED)) u_lfsr (
    .clk_i   (noc_clk),
    .rst_ni  (noc_rst_n),
    .en_i    (bp_enable),
    .state_o (lfsr_state)
  );

  assign lfsr_unused = lfsr_state[7:1];

  // Flit fields
  logic [NOC_MARK_W-1:0]   f_hmark, f_emark;
  logic [NOC_ID_WIDTH-1:0] f_src, f_dest;

  assign f_hmark = receive_flit[NOC_DATA_WIDTH-1:NOC_POINT_H];
  assign f_emark = receive_flit[AXI_LEN_POINT-1:NOC_POINT_E];
  assign f_src   = receive_flit[NOC_POINT_H-1:NOC_SOURCE_POINT];
  assign f_dest  = receive_flit[NOC_SOURCE_POINT-1:NOC_DEST_POINT];

  // State
  state_e                  state_q, state_d;
  logic [NOC_ID_WIDTH-1:0] src_q, src_d;
  logic [7:0]              len_q, len_d;
  err_code_e               code_q, code_d;
  logic                    ready_q;
  logic                    done_q, perr_q;
  logic [NOC_ID_WIDTH-1:0] osrc_q;
  logic [7:0]              olen_q;
  err_code_e               ocode_q;
  logic [15:0]             pcnt_q, ecnt_q;

  // Checker results
  logic       accept;
  err_code_e  hdr_code, data_code;
  logic       tail_mark_bad;
  logic [7:0] len_inc;

  assign accept        = receive_valid & ready_q;
  assign hdr_code      = (f_hmark != NOC_HEAD_H || f_emark != NOC_HEAD_E) ? ERR_HMARK :
                         (f_dest != OWN_ID)                              ? ERR_DEST  : ERR_NONE;
  assign tail_mark_bad = (f_hmark != NOC_TAIL_H) || (f_emark != NOC_TAIL_E);
  assign len_inc       = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
  assign data_code     = (int'(len_inc) > MAX_DATA_FLITS)              ? ERR_OVF  :
                         (CHECK_DATA && receive_flit != EXP_DATA)      ? ERR_DATA : ERR_NONE;

  // Next-state and close decision
  logic                    close, stray;
  logic [NOC_ID_WIDTH-1:0] close_src;
  logic [7:0]              close_len;
  err_code_e               close_code;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    len_d      = len_q;
    code_d     = code_q;
    close      = 1'b0;
    stray      = 1'b0;
    close_src  = src_q;
    close_len  = len_q;
    close_code = code_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (receive_is_header) begin
            src_d  = f_src;
            len_d  = '0;
            code_d = hdr_code;
            if (receive_is_tail) begin
              // Single-flit packet: the source check against itself is trivially met
              close      = 1'b1;
              close_src  = f_src;
              close_len  = '0;
              close_code = first_err(hdr_code, tail_mark_bad ? ERR_TAIL : ERR_NONE);
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            stray = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (receive_is_header) begin
            // Truncation: close the open packet. The same flit opens the next
            // packet. A tail flag on this flit is ignored.
            close      = 1'b1;
            close_code = first_err(code_q, ERR_TRUNC);
            src_d      = f_src;
            len_d      = '0;
            code_d     = hdr_code;
          end else if (receive_is_tail) begin
            close      = 1'b1;
            close_code = first_err(code_q,
                           (tail_mark_bad || f_src != src_q) ? ERR_TAIL : ERR_NONE);
            state_d    = ST_IDLE;
          end else begin
            len_d  = len_inc;
            code_d = first_err(code_q, data_code);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      len_q   <= '0;
      code_q  <= ERR_NONE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      osrc_q  <= '0;
      olen_q  <= '0;
      ocode_q <= ERR_NONE;
      pcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      len_q   <= len_d;
      code_q  <= code_d;
      ready_q <= bp_enable ? lfsr_state[0] : 1'b1;
      done_q  <= close;
      if (close) begin
        osrc_q  <= close_src;
        olen_q  <= close_len;
        ocode_q <= close_code;
        perr_q  <= (close_code != ERR_NONE);
        pcnt_q  <= sat_inc16(pcnt_q);
        if (close_code != ERR_NONE) ecnt_q <= sat_inc16(ecnt_q);
      end else if (stray) begin
        ecnt_q <= sat_inc16(ecnt_q);
      end
    end
  end

  assign receive_ready = ready_q;
  assign pkt_done      = done_q;
  assign pkt_src_x     = osrc_q[NOC_ID_WIDTH-1:NOC_ID_Y_WIDTH];
  assign pkt_src_y     = osrc_q[NOC_ID_Y_WIDTH-1:0];
  assign pkt_len       = olen_q;
  assign pkt_err       = perr_q;
  assign err_code      = ocode_q;
  assign pkt_count     = pcnt_q;
  assign err_count     = ecnt_q;

endmodule

// File: tb/tb_noc_packet_sink.sv
module tb_noc_packet_sink;

  logic        noc_clk = 1'b0, noc_rst_n = 1'b0;
  logic        receive_valid = 1'b0, receive_is_header = 1'b0, receive_is_tail = 1'b0;
  logic        bp_enable = 1'b0;
  logic [31:0] receive_flit = '0;

  logic        receive_ready, pkt_done, pkt_err;
  logic [3:0]  pkt_src_x, pkt_src_y;
  logic [7:0]  pkt_len;
  logic [2:0]  err_code;
  logic [15:0] pkt_count, err_count;

  logic        m_receive_ready, m_pkt_done, m_pkt_err;
  logic [3:0]  m_pkt_src_x, m_pkt_src_y;
  logic [7:0]  m_pkt_len;
  logic [2:0]  m_err_code;
  logic [15:0] m_pkt_count, m_err_count;

  int checks = 0, errors = 0;
  int done_cnt = 0, len_sum = 0, stall_cnt = 0;

  localparam logic [3:0]  MX  = 4'd3;
  localparam logic [3:0]  MY  = 4'd5;
  localparam logic [31:0] DAT = 32'hFFFF_FFFF;

  always #5 noc_clk = ~noc_clk;

  noc_packet_sink #(.X_ID(MX), .Y_ID(MY), .MAX_DATA_FLITS(16)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .receive_valid(receive_valid),
    .receive_ready(receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .bp_enable(bp_enable), .pkt_done(pkt_done), .pkt_src_x(pkt_src_x),
    .pkt_src_y(pkt_src_y), .pkt_len(pkt_len), .pkt_err(pkt_err),
    .err_code(err_code), .pkt_count(pkt_count), .err_count(err_count));

  // Same stimulus, tighter length limit
  noc_packet_sink #(.X_ID(MX), .Y_ID(MY), .MAX_DATA_FLITS(4)) dut4 (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .receive_valid(receive_valid),
    .receive_ready(m_receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .bp_enable(bp_enable), .pkt_done(m_pkt_done), .pkt_src_x(m_pkt_src_x),
    .pkt_src_y(m_pkt_src_y), .pkt_len(m_pkt_len), .pkt_err(m_pkt_err),
    .err_code(m_err_code), .pkt_count(m_pkt_count), .err_count(m_err_count));

  always @(posedge noc_clk) begin
    if (pkt_done) begin done_cnt++; len_sum += pkt_len; end
    if (receive_valid && !receive_ready) stall_cnt++;
  end

  function automatic logic [31:0] hdr(input logic [3:0] sx, sy, dx, dy);
    return {2'b10, sx, sy, dx, dy, 2'b01, 12'h000};
  endfunction

  function automatic logic [31:0] tl(input logic [3:0] sx, sy);
    return {2'b01, sx, sy, 8'h00, 2'b10, 12'h000};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [31:0] f, input logic h, input logic t);
    int n = 0;
    receive_valid = 1'b1; receive_flit = f; receive_is_header = h; receive_is_tail = t;
    while (!receive_ready && n < 1000) begin @(negedge noc_clk); n++; end
    if (!receive_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout ready=%b required 1", receive_ready);
    end
    @(negedge noc_clk);
    receive_valid = 1'b0; receive_is_header = 1'b0; receive_is_tail = 1'b0;
  endtask

  task automatic do_reset(input logic bp);
    receive_valid = 1'b0; receive_is_header = 1'b0; receive_is_tail = 1'b0;
    bp_enable = bp;
    noc_rst_n = 1'b0;
    repeat (2) @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(negedge noc_clk);
  endtask

  task automatic test_reset();
    noc_rst_n = 1'b0; bp_enable = 1'b0;
    @(negedge noc_clk);
    checks++; if (receive_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", receive_ready); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", pkt_done); end
    checks++; if ({pkt_count, err_count} !== 32'h0) begin errors++; $display("FAIL rst_counts got %h/%h want 0/0", pkt_count, err_count); end
    checks++; if ({pkt_src_x, pkt_src_y, pkt_len, pkt_err, err_code} !== 20'h0) begin
      errors++; $display("FAIL rst_status got src %0d,%0d len %0d err %b code %0d want all 0", pkt_src_x, pkt_src_y, pkt_len, pkt_err, err_code); end
    do_reset(1'b0);
  endtask

  task automatic test_clean();
    do_reset(1'b0);
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL clean_early_done got %b want 0", pkt_done); end
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL clean_done got %b want 1", pkt_done); end
    checks++; if (pkt_src_x !== 4'd1 || pkt_src_y !== 4'd2) begin errors++; $display("FAIL clean_src got %0d,%0d want 1,2", pkt_src_x, pkt_src_y); end
    checks++; if (pkt_len !== 8'd1) begin errors++; $display("FAIL clean_len got %0d want 1", pkt_len); end
    checks++; if (pkt_err !== 1'b0 || err_code !== 3'd0) begin errors++; $display("FAIL clean_err got %b/%0d want 0/0", pkt_err, err_code); end
    checks++; if (pkt_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL clean_counts got %0d/%0d want 1/0", pkt_count, err_count); end
    @(negedge noc_clk);
    checks++; if (pkt_done !== 1'b0 || pkt_len !== 8'd1) begin errors++; $display("FAIL clean_pulse got done %b len %0d want 0 1", pkt_done, pkt_len); end
  endtask

  task automatic test_dest();
    do_reset(1'b0);
    send(hdr(4'd1, 4'd2, MX + 4'd1, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (err_code !== 3'd2 || pkt_err !== 1'b1) begin errors++; $display("FAIL dest_code got %0d/%b want 2/1", err_code, pkt_err); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL dest_errcnt got %0d want 1", err_count); end
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (err_code !== 3'd0 || pkt_err !== 1'b0) begin errors++; $display("FAIL dest_next got %0d/%b want 0/0", err_code, pkt_err); end
    checks++; if (pkt_count !== 16'd2 || err_count !== 16'd1) begin errors++; $display("FAIL dest_counts got %0d/%0d want 2/1", pkt_count, err_count); end
  endtask

  task automatic test_stray();
    int d0;
    do_reset(1'b0);
    d0 = done_cnt;
    send(DAT, 1'b0, 1'b0);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL stray_done got %b want 0", pkt_done); end
    checks++; if (err_count !== 16'd1 || pkt_count !== 16'd0) begin errors++; $display("FAIL stray_counts got %0d/%0d want err 1 pkt 0", err_count, pkt_count); end
    send(hdr(4'd6, 4'd7, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd6, 4'd7), 1'b0, 1'b1);
    @(negedge noc_clk);
    checks++; if (pkt_count !== 16'd1 || err_count !== 16'd1) begin errors++; $display("FAIL stray_after got %0d/%0d want 1/1", pkt_count, err_count); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stray_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_trunc();
    do_reset(1'b0);
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(hdr(4'd3, 4'd4, MX, MY), 1'b1, 1'b0);
    checks++; if (pkt_done !== 1'b1 || err_code !== 3'd7 || pkt_len !== 8'd2 || pkt_src_x !== 4'd1) begin
      errors++; $display("FAIL trunc_first got done %b code %0d len %0d sx %0d want 1 7 2 1", pkt_done, err_code, pkt_len, pkt_src_x); end
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd3, 4'd4), 1'b0, 1'b1);
    checks++; if (pkt_done !== 1'b1 || err_code !== 3'd0 || pkt_len !== 8'd1 || pkt_src_x !== 4'd3) begin
      errors++; $display("FAIL trunc_second got done %b code %0d len %0d sx %0d want 1 0 1 3", pkt_done, err_code, pkt_len, pkt_src_x); end
    checks++; if (pkt_count !== 16'd2 || err_count !== 16'd1) begin errors++; $display("FAIL trunc_counts got %0d/%0d want 2/1", pkt_count, err_count); end
  endtask

  task automatic test_len_data();
    do_reset(1'b0);
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send((i == 2) ? 32'h0 : DAT, 1'b0, 1'b0);
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (m_err_code !== 3'd4 || m_pkt_len !== 8'd6 || m_pkt_err !== 1'b1) begin
      errors++; $display("FAIL data_first got code %0d len %0d err %b want 4 6 1", m_err_code, m_pkt_len, m_pkt_err); end
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(DAT, 1'b0, 1'b0);
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (m_err_code !== 3'd0 || m_pkt_len !== 8'd4) begin errors++; $display("FAIL len_at_max got code %0d len %0d want 0 4", m_err_code, m_pkt_len); end
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(DAT, 1'b0, 1'b0);
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (m_err_code !== 3'd5 || m_pkt_len !== 8'd5) begin errors++; $display("FAIL len_ovf got code %0d len %0d want 5 5", m_err_code, m_pkt_len); end
    checks++; if (err_code !== 3'd0 || pkt_len !== 8'd5) begin errors++; $display("FAIL len_big_limit got code %0d len %0d want 0 5", err_code, pkt_len); end
    checks++; if (m_pkt_count !== 16'd3 || m_err_count !== 16'd2) begin errors++; $display("FAIL len_counts got %0d/%0d want 3/2", m_pkt_count, m_err_count); end
  endtask

  task automatic test_markers();
    do_reset(1'b0);
    send({2'b11, 4'd1, 4'd2, MX, MY, 2'b01, 12'h000}, 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd1, 4'd2), 1'b0, 1'b1);
    checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL hmark_code got %0d want 3", err_code); end
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd7, 4'd7), 1'b0, 1'b1);
    checks++; if (err_code !== 3'd6 || pkt_src_x !== 4'd1) begin errors++; $display("FAIL tail_src got code %0d sx %0d want 6 1", err_code, pkt_src_x); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    send(hdr(4'd1, 4'd2, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    do_reset(1'b0);
    send(hdr(4'd2, 4'd3, MX, MY), 1'b1, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(DAT, 1'b0, 1'b0);
    send(tl(4'd2, 4'd3), 1'b0, 1'b1);
    checks++; if (err_code !== 3'd0 || pkt_len !== 8'd2 || pkt_count !== 16'd1) begin
      errors++; $display("FAIL reset_mid got code %0d len %0d cnt %0d want 0 2 1", err_code, pkt_len, pkt_count); end
  endtask

  task automatic test_back_to_back();
    int d0, l0, s0, exp_len, k;
    logic [3:0] sx;
    do_reset(1'b1);
    d0 = done_cnt; l0 = len_sum; s0 = stall_cnt; exp_len = 0;
    for (int p = 0; p < 200; p++) begin
      k = 1 + (p % 3);
      sx = 4'(p);
      exp_len += k;
      send(hdr(sx, 4'd9, MX, MY), 1'b1, 1'b0);
      for (int j = 0; j < k; j++) send(DAT, 1'b0, 1'b0);
      send(tl(sx, 4'd9), 1'b0, 1'b1);
    end
    repeat (3) @(negedge noc_clk);
    checks++; if (pkt_count !== 16'd200 || err_count !== 16'd0) begin errors++; $display("FAIL b2b_counts got %0d/%0d want 200/0", pkt_count, err_count); end
    checks++; if (done_cnt - d0 !== 200) begin errors++; $display("FAIL b2b_pulses got %0d want 200", done_cnt - d0); end
    checks++; if (len_sum - l0 !== exp_len) begin errors++; $display("FAIL b2b_len_sum got %0d want %0d", len_sum - l0, exp_len); end
    checks++; if (stall_cnt - s0 <= 0) begin errors++; $display("FAIL b2b_stalls got %0d want >0", stall_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_dest();
    test_stray();
    test_trunc();
    test_len_data();
    test_markers();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
